// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared constants and state type for the RAM stream reader
package ram_rd_pkg;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int MAX_LEN = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - small shift-style FIFO whose entry 0 is the registered output head
module stream_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] occupancy
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wr_idx;

  assign wr_idx     = count - CNT_W'(pop);
  assign head_data  = mem[0];
  assign head_valid = (count != '0);
  assign occupancy  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      // A push lands behind whatever survives this edge's pop.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_idx == i[CNT_W-1:0]) mem[i] <= push_data;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - walks a RAM address range and emits the words as a valid/ready stream
module ram_stream_reader #(
  parameter int ADDR_W    = ram_rd_pkg::ADDR_W,
  parameter int DATA_W    = ram_rd_pkg::DATA_W,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  import ram_rd_pkg::*;

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int LD_W  = CNT_W + 1;
  localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_LEN);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, len_sat;
  logic [1:0]       infl, infl_last;
  logic [CNT_W-1:0] occupancy;
  logic [DATA_W:0]  head;
  logic [LD_W-1:0]  load;
  logic             head_valid, pop, finish, credit_ok;
  logic             issue, issue_first, issue_last, null_cmd;

  assign len_sat = (len > LEN_CAP) ? LEN_CAP : len;
  assign pop     = head_valid & out_ready;
  assign finish  = pop & head[DATA_W];

  // Buffered plus in-flight words, after this edge's pop, must leave room for one more.
  assign load      = LD_W'(occupancy) + LD_W'(infl[0]) + LD_W'(infl[1]) - LD_W'(pop);
  assign credit_ok = load < LD_W'(BUF_DEPTH);

  stream_sync_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_W + 1),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (infl[1]),
    .push_data  ({infl_last[1], rdata}),
    .pop        (pop),
    .flush      (abort),
    .head_data  (head),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue_first = 1'b0;
    issue_last  = 1'b0;
    null_cmd    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_sat == '0) begin
            null_cmd = 1'b1;
          end else begin
            issue       = 1'b1;
            issue_first = 1'b1;
            issue_last  = (len_sat == LEN_W'(1));
            state_nxt   = (len_sat == LEN_W'(1)) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (remaining != '0 && credit_ok) begin
          issue      = 1'b1;
          issue_last = (remaining == LEN_W'(1));
          if (remaining == LEN_W'(1)) state_nxt = DRAIN;
        end
        if (finish) state_nxt = IDLE;
      end
      DRAIN: begin
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt   = IDLE;
      issue       = 1'b0;
      issue_first = 1'b0;
      issue_last  = 1'b0;
      null_cmd    = 1'b0;
    end
  end

  // The RAM reads every cycle, so returning words are tracked by position, not address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr     <= '0;
      remaining <= '0;
      infl      <= '0;
      infl_last <= '0;
      done      <= 1'b0;
    end else begin
      done <= null_cmd | (finish & ~abort);
      if (abort) begin
        infl      <= '0;
        infl_last <= '0;
        remaining <= '0;
      end else begin
        infl      <= {infl[0], issue};
        infl_last <= {infl_last[0], issue_last};
        if (issue_first) begin
          raddr     <= start_addr;
          remaining <= len_sat - 1'b1;
        end else if (issue) begin
          raddr     <= raddr + 1'b1;
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

  assign out_valid = head_valid;
  assign out_data  = head[DATA_W-1:0];
  assign out_last  = head_valid & head[DATA_W];
  assign busy      = (state != IDLE);
endmodule
